// File: rtl/soc_system_onchip_memory_scanner.sv
// Avalon-MM host engine for the 1024 x 32 on-chip RAM. It fills, checksums or
// verifies a wrapping range of words at one access per clock.
module soc_system_onchip_memory_scanner #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  incr,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       count,
    input  logic [DATA_W-1:0]     pattern,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  aborted,
    output logic [DATA_W-1:0]     result,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [1:0] MODE_FILL   = 2'b00;
    localparam logic [1:0] MODE_SUM    = 2'b01;
    localparam logic [1:0] MODE_VERIFY = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;
    localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic                incr_q, incr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   pattern_q, pattern_d;
    logic                rdVld_q, rdVld_d;
    logic [ADDR_W-1:0]   rdIdx_q, rdIdx_d;
    logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                error_q, error_d;
    logic                aborted_q, aborted_d;
    logic [ADDR_W-1:0]   firstErr_q, firstErr_d;
    logic [DATA_W-1:0]   wrPattern, rdExpected;

    assign wrPattern  = pattern_q + (incr_q ? DATA_W'(idx_q) : '0);
    assign rdExpected = pattern_q + (incr_q ? DATA_W'(rdIdx_q) : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_FILL;
            incr_q     <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            pattern_q  <= '0;
            rdVld_q    <= 1'b0;
            rdIdx_q    <= '0;
            rdAddr_q   <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            aborted_q  <= 1'b0;
            firstErr_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            incr_q     <= incr_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            pattern_q  <= pattern_d;
            rdVld_q    <= rdVld_d;
            rdIdx_q    <= rdIdx_d;
            rdAddr_q   <= rdAddr_d;
            result_q   <= result_d;
            error_q    <= error_d;
            aborted_q  <= aborted_d;
            firstErr_q <= firstErr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        incr_d     = incr_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        pattern_d  = pattern_q;
        rdVld_d    = 1'b0;
        rdIdx_d    = idx_q;
        rdAddr_d   = addr_q;
        result_d   = result_q;
        error_d    = error_q;
        aborted_d  = aborted_q;
        firstErr_d = firstErr_q;

        // Read data arrives one cycle after its address; a zero mismatch count marks the first one.
        if (rdVld_q) begin
            if (mode_q == MODE_SUM) begin
                result_d = result_q + m_readdata;
            end else if (m_readdata != rdExpected) begin
                if (result_q == '0) firstErr_d = rdAddr_q;
                if (result_q < DATA_W'(DEPTH)) result_d = result_q + DATA_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    incr_d     = incr;
                    addr_d     = base_addr;
                    idx_d      = '0;
                    pattern_d  = pattern;
                    rem_d      = (count > DEPTH) ? DEPTH : count;
                    result_d   = '0;
                    error_d    = 1'b0;
                    aborted_d  = 1'b0;
                    firstErr_d = '0;
                    if (count == '0 || mode == MODE_RSVD) begin
                        state_d = FIN;
                        error_d = (mode == MODE_RSVD);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                addr_d = addr_q + ADDR_W'(1);
                idx_d  = idx_q + ADDR_W'(1);
                rem_d  = rem_q - (ADDR_W+1)'(1);
                if (mode_q == MODE_FILL) result_d = result_q + DATA_W'(1);
                else                     rdVld_d  = 1'b1;
                if (abort) aborted_d = 1'b1;
                if (abort || rem_q == (ADDR_W+1)'(1))
                    state_d = (mode_q == MODE_FILL) ? FIN : DRAIN;
            end
            DRAIN:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == DRAIN && mode_q == MODE_VERIFY && result_d != '0)
            error_d = 1'b1;
    end

    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == FIN);
    assign error          = error_q;
    assign aborted        = aborted_q;
    assign result         = result_q;
    assign first_err_addr = firstErr_q;
    assign m_chipselect   = (state_q == RUN);
    assign m_write        = m_chipselect && (mode_q == MODE_FILL);
    assign m_address      = m_chipselect ? addr_q : '0;
    assign m_writedata    = m_write ? wrPattern : '0;
    assign m_byteenable   = {(DATA_W/8){m_chipselect}};
    assign m_clken        = 1'b1;

endmodule

// File: tb/tb_soc_system_onchip_memory_scanner.sv
// Randomized bench for the memory scanner: a behavioural RAM slave plus a
// range-level reference model of fill, sum and verify jobs.
module tb_soc_system_onchip_memory_scanner;

    logic        clk, reset_n, start, incr, abort;
    logic [1:0]  mode;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic [31:0] pattern;
    logic        busy, done, error, aborted;
    logic [31:0] result;
    logic [9:0]  first_err_addr, m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write, m_clken;
    logic [31:0] m_writedata, m_readdata;

    int totalChecks = 0;
    int badChecks = 0;
    int cyc = 0;

    logic [31:0] mem [1024];
    logic [31:0] refMem [1024];
    logic        loadReq = 1'b0;
    logic [9:0]  rdAddrReg = '0;

    soc_system_onchip_memory_scanner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .incr(incr),
        .base_addr(base_addr), .count(count), .pattern(pattern), .abort(abort),
        .busy(busy), .done(done), .error(error), .aborted(aborted), .result(result),
        .first_err_addr(first_err_addr), .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
        .m_clken(m_clken), .m_readdata(m_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM slave: registered address, unregistered read data.
    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < 1024; i++) mem[i] <= refMem[i];
        end else if (m_clken && m_chipselect) begin
            if (m_write) mem[m_address] <= m_writedata;
            rdAddrReg <= m_address;
        end
    end
    assign m_readdata = mem[rdAddrReg];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "busy"}, 32'(busy), 0);
        checkOutput({pfx, "done"}, 32'(done), 0);
        checkOutput({pfx, "error"}, 32'(error), 0);
        checkOutput({pfx, "aborted"}, 32'(aborted), 0);
        checkOutput({pfx, "chipselect"}, 32'(m_chipselect), 0);
        checkOutput({pfx, "write"}, 32'(m_write), 0);
        checkOutput({pfx, "result"}, result, 0);
        checkOutput({pfx, "firstErr"}, 32'(first_err_addr), 0);
        checkOutput({pfx, "address"}, 32'(m_address), 0);
        checkOutput({pfx, "writedata"}, m_writedata, 0);
        checkOutput({pfx, "byteenable"}, 32'(m_byteenable), 0);
        checkOutput({pfx, "clken"}, 32'(m_clken), 1);
    endtask

    task automatic loadMemory();
        @(negedge clk) loadReq = 1'b1;
        @(negedge clk) loadReq = 1'b0;
    endtask

    // abortAt: access index at which abort is raised, -1 none, -2 raised together with start.
    task automatic applyStimulus(input logic [1:0] md, input logic inc, input logic [9:0] base,
                                 input logic [10:0] cnt, input logic [31:0] pat,
                                 input int abortAt, input bit pokeStart);
        int n, issued, mism, eCyc, rel, doneRel, busyCnt, accCnt, accBad, memBad;
        int expDoneRel, expBusy;
        bit gotDone;
        logic [31:0] expResult, d, obsResult;
        logic [9:0] a, expFirst, obsFirst;
        logic expErr, expAborted, obsErr, obsAborted;

        n = (md == 2'b11) ? 0 : ((int'(cnt) > 1024) ? 1024 : int'(cnt));
        issued = (abortAt >= 0 && abortAt < n) ? abortAt + 1 : n;
        expAborted = (abortAt >= 0 && abortAt < n);
        expResult = '0;
        expFirst = '0;
        mism = 0;
        for (int k = 0; k < issued; k++) begin
            a = 10'(int'(base) + k);
            d = pat + (inc ? 32'(k) : 32'd0);
            if (md == 2'b01) expResult = expResult + refMem[a];
            if (md == 2'b10 && refMem[a] != d) begin
                if (mism == 0) expFirst = a;
                mism++;
            end
        end
        if (md == 2'b00) expResult = 32'(issued);
        if (md == 2'b10) expResult = 32'((mism > 1024) ? 1024 : mism);
        expErr = (md == 2'b11) || (md == 2'b10 && mism > 0);
        expDoneRel = (n == 0) ? 1 : ((md == 2'b00) ? issued + 1 : issued + 2);
        expBusy = (n == 0) ? 0 : ((md == 2'b00) ? issued : issued + 1);

        @(negedge clk);
        mode = md; incr = inc; base_addr = base; count = cnt; pattern = pat;
        start = 1'b1;
        abort = (abortAt == -2);
        eCyc = cyc;
        gotDone = 0; doneRel = 0; busyCnt = 0; accCnt = 0; accBad = 0;
        obsResult = '0; obsFirst = '0; obsErr = 1'b0; obsAborted = 1'b0;
        for (int t = 0; t < 2200 && !gotDone; t++) begin
            @(negedge clk);
            rel = cyc - eCyc;
            if (m_chipselect) begin
                a = 10'(int'(base) + accCnt);
                d = pat + (inc ? 32'(accCnt) : 32'd0);
                if (accCnt >= issued || m_address !== a || m_write !== (md == 2'b00) ||
                    m_byteenable !== 4'hF || (md == 2'b00 && m_writedata !== d)) begin
                    accBad++;
                    if (accBad == 1)
                        $display("[TB] access %0d wrong: addr=%h wr=%b data=%h (want addr=%h data=%h)",
                                 accCnt, m_address, m_write, m_writedata, a, d);
                end
                accCnt++;
            end
            if (busy) busyCnt++;
            if (done) begin
                gotDone = 1;
                doneRel = rel;
                obsResult = result; obsErr = error; obsAborted = aborted; obsFirst = first_err_addr;
            end
            start = pokeStart && !done && (rel == 2 || rel == 3);
            if (pokeStart && rel == 2) begin
                base_addr = ~base;
                mode = 2'b01;
            end
            abort = (abortAt >= 0) && (rel == 1 + abortAt) && !done;
        end
        start = 1'b0;
        abort = 1'b0;

        checkOutput("doneSeen", 32'(gotDone), 1);
        checkOutput("doneLatency", 32'(doneRel), 32'(expDoneRel));
        checkOutput("busyCycles", 32'(busyCnt), 32'(expBusy));
        checkOutput("accessCount", 32'(accCnt), 32'(issued));
        checkOutput("accessSeq", 32'(accBad), 0);
        checkOutput("result", obsResult, expResult);
        checkOutput("error", 32'(obsErr), 32'(expErr));
        checkOutput("aborted", 32'(obsAborted), 32'(expAborted));
        checkOutput("firstErr", 32'(obsFirst), 32'(expFirst));

        @(negedge clk);
        checkOutput("donePulse", 32'(done), 0);
        checkOutput("resultHold", result, expResult);

        if (md == 2'b00)
            for (int k = 0; k < issued; k++)
                refMem[10'(int'(base) + k)] = pat + (inc ? 32'(k) : 32'd0);
        memBad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== refMem[i]) memBad++;
        checkOutput("memImage", 32'(memBad), 0);
    endtask

    initial begin
        logic [1:0]  rMode;
        logic        rInc;
        logic [9:0]  rBase;
        logic [10:0] rCnt;
        logic [31:0] rPat;
        int          rAbort;

        reset_n = 1'b1; start = 1'b0; abort = 1'b0; incr = 1'b0; mode = '0;
        base_addr = '0; count = '0; pattern = '0;
        #1 reset_n = 1'b0;
        #2 checkReset("rst_");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 1024; i++) refMem[i] = $urandom;
        loadMemory();

        applyStimulus(2'b00, 1'b1, 10'h3FE, 11'd4, 32'hA0000000, -1, 0);
        applyStimulus(2'b01, 1'b0, 10'h3FE, 11'd4, 32'h0, -1, 0);
        applyStimulus(2'b01, 1'b0, 10'h3F0, 11'd40, 32'h0, -2, 0);

        for (int i = 0; i < 1024; i++) refMem[i] = 32'h5A5A5A5A;
        refMem[10'h123] = 32'h0;
        loadMemory();
        applyStimulus(2'b10, 1'b0, 10'h200, 11'd1024, 32'h5A5A5A5A, -1, 0);

        applyStimulus(2'b00, 1'b0, 10'h050, 11'd0, 32'h12345678, -1, 0);
        applyStimulus(2'b11, 1'b0, 10'h050, 11'd8, 32'h12345678, -1, 0);
        applyStimulus(2'b00, 1'b1, 10'h100, 11'd16, 32'h11110000, 3, 1);
        applyStimulus(2'b00, 1'b0, 10'h2AA, 11'd1100, 32'hC3C3C3C3, -1, 0);
        applyStimulus(2'b10, 1'b0, 10'h2AA, 11'd2047, 32'hC3C3C3C3, -1, 0);
        applyStimulus(2'b10, 1'b1, 10'h3FC, 11'd30, 32'h0000FFFE, 5, 0);

        for (int j = 0; j < 10; j++) begin
            rMode = 2'($urandom_range(0, 3));
            rInc = 1'($urandom);
            rBase = 10'($urandom);
            rCnt = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(1025, 2047)) : 11'($urandom_range(0, 40));
            rPat = $urandom;
            rAbort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rCnt))) : -1;
            applyStimulus(rMode, rInc, rBase, rCnt, rPat, rAbort, 0);
            if (rMode == 2'b00) applyStimulus(2'b10, rInc, rBase, rCnt, rPat, -1, 0);
        end

        @(negedge clk);
        mode = 2'b01; incr = 1'b0; base_addr = 10'h100; count = 11'd200; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1 checkReset("midRst_");
        @(negedge clk) reset_n = 1'b1;
        applyStimulus(2'b01, 1'b0, 10'h100, 11'd200, 32'h0, -1, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
